// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared posit types, rounding modes and special-value constants
package posit_pkg;

  typedef enum logic [1:0] {
    RND_RNE = 2'd0,
    RND_RTZ = 2'd1,
    RND_RAZ = 2'd2
  } round_mode_t;

  // Control portion of an unpacked arithmetic result travelling with the body
  typedef struct packed {
    logic sign;
    logic sticky;
    logic inf;
    logic zero;
  } res_flags_t;

  function automatic logic [63:0] maxpos_f(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] minpos_f(input int n);
    return (n > 0) ? 64'd1 : 64'd0;
  endfunction

  function automatic logic [63:0] nar_f(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/posit_regime_shift.sv
// rtl/posit_regime_shift.sv - builds the left-aligned {regime, terminator, exp, frac} body
module posit_regime_shift
  import posit_pkg::*;
#(
  parameter int N  = 16,
  parameter int ES = 1,
  parameter int FW = 2 * N,
  parameter int RS = $clog2(N) + 1,
  parameter int BW = N + 1 + FW + ES
) (
  input  logic [RS-1:0]                k_i,
  input  logic [((ES > 0) ? ES : 1)-1:0] exp_i,
  input  logic [FW-1:0]                frac_i,
  output logic [BW-1:0]                body_o
);

  localparam int TW = ES + FW;

  logic [TW-1:0] tail;
  logic [BW-1:0] tail_al;

  generate
    if (ES > 0) begin : g_exp
      assign tail = {exp_i, frac_i};
    end else begin : g_noexp
      logic unused_exp;
      assign unused_exp = ^exp_i;
      assign tail = frac_i;
    end
  endgenerate

  assign tail_al = {tail, {(BW - TW){1'b0}}};

  always_comb begin
    int kv;
    int rl;
    logic [BW-1:0] run;
    kv = int'($signed(k_i));
    // rl is the regime length including its terminator; saturated k is clamped downstream
    rl = (kv >= 0) ? kv + 2 : 1 - kv;
    if (rl > BW) rl = BW;
    if (kv >= 0) run = ~({BW{1'b1}} >> (rl - 1));
    else         run = {{(BW - 1){1'b0}}, 1'b1} << (BW - rl);
    body_o = run | (tail_al >> rl);
  end

endmodule

// File: rtl/posit_round_pack.sv
// rtl/posit_round_pack.sv - 2-stage posit round/pack with valid/ready handshake
// Optional POSIT_RND_MODE_EN adds the in_rmode port (RNE/RTZ/RAZ); otherwise fixed RNE.
module posit_round_pack
  import posit_pkg::*;
#(
  parameter int N  = 16,
  parameter int ES = 1,
  parameter int FW = 2 * N,
  parameter int RS = $clog2(N) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sign,
  input  logic [RS-1:0]                in_k,
  input  logic [((ES > 0) ? ES : 1)-1:0] in_exp,
  input  logic [FW-1:0]                in_frac,
  input  logic                         in_sticky,
  input  logic                         in_inf,
  input  logic                         in_zero,
`ifdef POSIT_RND_MODE_EN
  input  logic [1:0]                   in_rmode,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0]                 out_posit,
  output logic                         out_inexact
);

  localparam int BW = N + 1 + FW + ES;
  localparam logic [N-1:0] MAXPOS = N'(maxpos_f(N));
  localparam logic [N-1:0] MINPOS = N'(minpos_f(N));
  localparam logic [N-1:0] NAR    = N'(nar_f(N));
  localparam logic signed [RS-1:0] K_HI = RS'(N - 2);
  localparam logic signed [RS-1:0] K_LO = RS'(-(N - 1));

  logic                 v1_q, v2_q;
  logic                 s1_ld, s2_ld;
  res_flags_t           flags_q;
  logic signed [RS-1:0] k_q;
  logic [BW-1:0]        body_d, body_q;
  logic [N-1:0]         posit_d, posit_q;
  logic                 inexact_d, inexact_q;
`ifdef POSIT_RND_MODE_EN
  logic [1:0]           rmode_q;
`endif

  assign s2_ld     = !v2_q || out_ready;
  assign s1_ld     = !v1_q || s2_ld;
  assign in_ready  = s1_ld;
  assign out_valid = v2_q;
  assign out_posit = posit_q;
  assign out_inexact = inexact_q;

  posit_regime_shift #(.N(N), .ES(ES), .FW(FW), .RS(RS), .BW(BW)) u_shift (
    .k_i    (in_k),
    .exp_i  (in_exp),
    .frac_i (in_frac),
    .body_o (body_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      flags_q <= '0;
      k_q     <= '0;
      body_q  <= '0;
`ifdef POSIT_RND_MODE_EN
      rmode_q <= 2'd0;
`endif
    end else if (s1_ld) begin
      v1_q <= in_valid;
      if (in_valid) begin
        flags_q <= {in_sign, in_sticky, in_inf, in_zero};
        k_q     <= in_k;
        body_q  <= body_d;
`ifdef POSIT_RND_MODE_EN
        rmode_q <= in_rmode;
`endif
      end
    end
  end

  always_comb begin
    logic [N-2:0] kept;
    logic         g_bit, s_bit, l_bit, inc, inexact;
    logic [N-1:0] mag, word;
    kept  = body_q[BW-1 -: N-1];
    l_bit = kept[0];
    g_bit = body_q[BW-N];
    s_bit = (|body_q[BW-N-1:0]) | flags_q.sticky;
`ifdef POSIT_RND_MODE_EN
    case (rmode_q)
      RND_RTZ: inc = 1'b0;
      RND_RAZ: inc = g_bit | s_bit;
      default: inc = g_bit & (s_bit | l_bit);
    endcase
`else
    inc = g_bit & (s_bit | l_bit);
`endif
    mag     = {1'b0, kept} + {{(N-1){1'b0}}, inc};
    inexact = g_bit | s_bit;
    // Clamp keeps a nonzero value away from both zero and NaR
    if (k_q >= K_HI || mag[N-1]) begin
      mag     = MAXPOS;
      inexact = 1'b1;
    end else if (k_q <= K_LO || mag == '0) begin
      mag     = MINPOS;
      inexact = 1'b1;
    end
    word       = flags_q.sign ? -mag : mag;
    word[N-1]  = flags_q.sign;
    if (flags_q.inf) begin
      word    = NAR;
      inexact = 1'b0;
    end else if (flags_q.zero) begin
      word    = '0;
      inexact = 1'b0;
    end
    posit_d   = word;
    inexact_d = inexact;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v2_q      <= 1'b0;
      posit_q   <= '0;
      inexact_q <= 1'b0;
    end else if (s2_ld) begin
      v2_q <= v1_q;
      if (v1_q) begin
        posit_q   <= posit_d;
        inexact_q <= inexact_d;
      end
    end
  end

endmodule

// File: tb/tb_posit_round_pack.sv
// tb/tb_posit_round_pack.sv - self-checking bench for posit_round_pack (N=8, ES=0, FW=8)
module tb_posit_round_pack;
  localparam int N  = 8;
  localparam int ES = 0;
  localparam int FW = 8;
  localparam int RS = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_sign, in_sticky, in_inf, in_zero;
  logic [RS-1:0] in_k;
  logic [0:0]    in_exp;
  logic [FW-1:0] in_frac;
  logic [1:0]    in_rmode;
  logic          out_valid, out_ready, out_inexact;
  logic [N-1:0]  out_posit;

  always #5 clk = ~clk;

  posit_round_pack #(.N(N), .ES(ES), .FW(FW), .RS(RS)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_k        (in_k),
    .in_exp      (in_exp),
    .in_frac     (in_frac),
    .in_sticky   (in_sticky),
    .in_inf      (in_inf),
    .in_zero     (in_zero),
`ifdef POSIT_RND_MODE_EN
    .in_rmode    (in_rmode),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_posit   (out_posit),
    .out_inexact (out_inexact)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] sb[$];
  logic       dir_mode = 1'b0;
  logic [8:0] dir_exp;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_posit;
  logic       prev_inx;
  int         rready_low;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: posit bit string as an integer, truncated to N-1 bits, then rounded
  function automatic logic [8:0] ref_model(input logic s, input int k, input logic [7:0] f,
                                           input logic st, input logic inf, input logic zr,
                                           input int rm);
    longint full;
    int     len, cut, mag;
    logic   g, stk, inc, inx;
    if (inf) return 9'h080;
    if (zr)  return 9'h000;
    if (k >= N - 2) begin
      mag = 127; inx = 1'b1;
    end else if (k <= -(N - 1)) begin
      mag = 1; inx = 1'b1;
    end else begin
      if (k >= 0) begin
        full = ((64'd1 << (k + 1)) - 1) << 1;
        len  = k + 2;
      end else begin
        full = 1;
        len  = 1 - k;
      end
      full = (full << FW) | longint'(f);
      len  = len + FW;
      cut  = len - (N - 1);
      g    = ((full >> (cut - 1)) & 64'd1) != 0;
      stk  = ((full & ((64'd1 << (cut - 1)) - 1)) != 0) || st;
      full = full >> cut;
      case (rm)
        1:       inc = 1'b0;
        2:       inc = g | stk;
        default: inc = g & (stk | full[0]);
      endcase
      mag = int'(full) + int'(inc);
      inx = g | stk;
    end
    return {inx, s ? 8'(256 - mag) : 8'(mag)};
  endfunction

  task automatic step();
    logic [8:0] e;
    int rm;
    @(negedge clk);
    if (reset) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
      if (prev_stall) begin
        check("stall_posit", out_posit, prev_posit);
        check("stall_inexact", out_inexact, prev_inx);
      end
      if (out_valid && out_ready) begin
        check("no_spurious", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("posit", out_posit, e[7:0]);
          check("inexact", out_inexact, e[8]);
        end
      end
      if (in_valid && in_ready) begin
`ifdef POSIT_RND_MODE_EN
        rm = int'(in_rmode);
`else
        rm = 0;
`endif
        sb.push_back(dir_mode ? dir_exp :
                     ref_model(in_sign, int'($signed(in_k)), in_frac, in_sticky, in_inf, in_zero, rm));
      end
      prev_stall = out_valid && !out_ready;
      prev_posit = out_posit;
      prev_inx   = out_inexact;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input int k, input logic [7:0] f, input logic s,
                          input logic inf, input logic zr, input logic [1:0] rm,
                          input logic [7:0] ep, input logic ex);
    in_k = 4'(k); in_frac = f; in_sign = s; in_inf = inf; in_zero = zr; in_sticky = 1'b0;
    in_rmode = rm; in_valid = 1'b1; out_ready = 1'b1;
    dir_mode = 1'b1; dir_exp = {ex, ep};
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check({tag, "_drain"}, sb.size(), 0);
    dir_mode = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_k = '0; in_exp = '0; in_frac = '0;
    in_sticky = 1'b0; in_inf = 1'b0; in_zero = 1'b0; in_rmode = 2'd0; out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_posit", out_posit, 0);
    check("rst_out_inexact", out_inexact, 0);
    check("rst_in_ready", in_ready, 1);

    directed("k0",      0,  8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h40, 1'b0);
    directed("k0_neg",  0,  8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'hC0, 1'b0);
    directed("rne_up",  0,  8'h0C, 1'b0, 1'b0, 1'b0, 2'd0, 8'h42, 1'b1);
    directed("rne_tie", 0,  8'h04, 1'b0, 1'b0, 1'b0, 2'd0, 8'h40, 1'b1);
    directed("rne_gs",  0,  8'h05, 1'b0, 1'b0, 1'b0, 2'd0, 8'h41, 1'b1);
    directed("neg_rnd", 0,  8'h0C, 1'b1, 1'b0, 1'b0, 2'd0, 8'hBE, 1'b1);
    directed("carry",   -1, 8'hFC, 1'b0, 1'b0, 1'b0, 2'd0, 8'h40, 1'b1);
    directed("maxpos",  6,  8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h7F, 1'b1);
    directed("minpos",  -7, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h01, 1'b1);
    directed("minneg",  -8, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'hFF, 1'b1);
    directed("nar",     3,  8'h55, 1'b1, 1'b1, 1'b1, 2'd0, 8'h80, 1'b0);
    directed("zero",    3,  8'h55, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);
`ifdef POSIT_RND_MODE_EN
    directed("rtz",     0,  8'h0C, 1'b0, 1'b0, 1'b0, 2'd1, 8'h41, 1'b1);
    directed("raz",     0,  8'h01, 1'b0, 1'b0, 1'b0, 2'd2, 8'h41, 1'b1);
    directed("rsv_rne", 0,  8'h0C, 1'b0, 1'b0, 1'b0, 2'd3, 8'h42, 1'b1);
`endif

    // Randomized stream against the reference model with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_sign   = 1'($urandom_range(0, 1));
      in_k      = 4'($urandom_range(0, 15));
      in_frac   = 8'($urandom_range(0, 255));
      in_sticky = ($urandom_range(0, 3) == 0);
      in_inf    = ($urandom_range(0, 15) == 0);
      in_zero   = ($urandom_range(0, 15) == 0);
      in_rmode  = 2'($urandom_range(0, 3));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("rand_drain", sb.size(), 0);

    // Back-to-back beats with out_ready pattern 1,0,0,1
    in_inf = 1'b0; in_zero = 1'b0; in_rmode = 2'd0;
    rready_low = 0;
    for (int i = 0; i < 14; i++) begin
      in_valid  = (i < 8);
      in_k      = 4'(i - 3);
      in_frac   = 8'(i * 37 + 5);
      in_sign   = i[0];
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      #1;
      if (!in_ready) rready_low++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("b2b_drain", sb.size(), 0);
    check("b2b_in_ready_fell", rready_low > 0, 1);

    // Reset with two beats in flight
    out_ready = 1'b0; in_valid = 1'b1; in_k = 4'd1; in_frac = 8'h33;
    step(); step();
    in_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_posit", out_posit, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_no_stale", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
